data_memory_arbiter: RTL and testbench

Shares the single-port data memory between two requesters: the CPU load/store stage and the program/data loader (test and boot preload). It arbitrates per cycle with a burst-limited round-robin policy, drives the memory's address, write-data, write-enable and read-enable pins, and returns registered read data to whichever requester issued the read. It sits between the execute stage / loader and `data_memory_unit`.

---
 rtl/data_memory_arbiter_pkg.sv | 19 +
 rtl/data_memory_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_data_memory_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter between the CPU
// load/store stage and the program/data loader.
package data_memory_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_MEM_DEPTH  = 512;
  localparam int DEF_MAX_BURST  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_OWN = 2'd1,
    LDR_OWN = 2'd2
  } arb_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

endpackage

// File: rtl/data_memory_arbiter.sv
// Burst-limited round-robin arbiter sharing one single-port data memory
// between the CPU and the loader; returns registered read data to the reader.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  ldr_req,
  input  logic                  ldr_we,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0] ldr_wdata,
  output logic                  cpu_gnt,
  output logic                  ldr_gnt,
  output logic                  cpu_rvalid,
  output logic                  ldr_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  output logic                  mem_read_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_CPU_OWN = CPU_OWN;
  localparam logic [1:0] ST_LDR_OWN = LDR_OWN;

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]    LP_BURST_MAX  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0]    LP_BURST_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]    LP_BURST_ZERO = CNT_W'(0);
  // One extra bit so a depth of exactly 2**ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0] LP_DEPTH      = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_burst_cnt;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_cpu_rvalid;
  logic                  r_ldr_rvalid;
  logic                  r_err;

  logic [1:0]            w_next_state;
  logic [CNT_W-1:0]      w_next_burst;
  logic [CNT_W-1:0]      w_burst_inc;
  logic                  w_cpu_sel;
  logic                  w_ldr_sel;
  logic                  w_cpu_gnt;
  logic                  w_ldr_gnt;
  logic                  w_gnt_any;
  logic                  w_sel_id;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_in_range;

  assign w_burst_inc = (r_burst_cnt >= LP_BURST_MAX) ? LP_BURST_MAX
                                                     : r_burst_cnt + LP_BURST_ONE;

  // Per-cycle owner decision: the owner keeps the memory until its burst
  // saturates while the other side waits; IDLE favours the CPU.
  always_comb begin
    w_cpu_sel    = 1'b0;
    w_ldr_sel    = 1'b0;
    w_next_state = ST_IDLE;
    w_next_burst = LP_BURST_ZERO;
    case (r_state)
      ST_CPU_OWN: begin
        if (cpu_req && ((r_burst_cnt < LP_BURST_MAX) || !ldr_req)) begin
          w_cpu_sel    = 1'b1;
          w_next_state = ST_CPU_OWN;
          w_next_burst = w_burst_inc;
        end else if (ldr_req) begin
          w_ldr_sel    = 1'b1;
          w_next_state = ST_LDR_OWN;
          w_next_burst = LP_BURST_ONE;
        end else begin
          w_next_state = ST_IDLE;
          w_next_burst = LP_BURST_ZERO;
        end
      end
      ST_LDR_OWN: begin
        if (ldr_req && ((r_burst_cnt < LP_BURST_MAX) || !cpu_req)) begin
          w_ldr_sel    = 1'b1;
          w_next_state = ST_LDR_OWN;
          w_next_burst = w_burst_inc;
        end else if (cpu_req) begin
          w_cpu_sel    = 1'b1;
          w_next_state = ST_CPU_OWN;
          w_next_burst = LP_BURST_ONE;
        end else begin
          w_next_state = ST_IDLE;
          w_next_burst = LP_BURST_ZERO;
        end
      end
      default: begin
        if (cpu_req) begin
          w_cpu_sel    = 1'b1;
          w_next_state = ST_CPU_OWN;
          w_next_burst = LP_BURST_ONE;
        end else if (ldr_req) begin
          w_ldr_sel    = 1'b1;
          w_next_state = ST_LDR_OWN;
          w_next_burst = LP_BURST_ONE;
        end else begin
          w_next_state = ST_IDLE;
          w_next_burst = LP_BURST_ZERO;
        end
      end
    endcase
  end

  // Grants are suppressed for the whole cycle in which reset is asserted.
  assign w_cpu_gnt = reset_n & w_cpu_sel;
  assign w_ldr_gnt = reset_n & w_ldr_sel;
  assign w_gnt_any = w_cpu_gnt | w_ldr_gnt;

  // Route the granted requester's fields to the memory; zeros when idle.
  always_comb begin
    w_sel_id    = w_ldr_gnt ? REQ_LDR : REQ_CPU;
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    if (w_gnt_any) begin
      if (w_sel_id == REQ_LDR) begin
        w_sel_we    = ldr_we;
        w_sel_addr  = ldr_addr;
        w_sel_wdata = ldr_wdata;
      end else begin
        w_sel_we    = cpu_we;
        w_sel_addr  = cpu_addr;
        w_sel_wdata = cpu_wdata;
      end
    end else begin
      w_sel_we    = 1'b0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
    end
  end

  assign w_in_range = ({1'b0, w_sel_addr} < LP_DEPTH);

  assign mem_address      = w_sel_addr;
  assign mem_write_data   = w_sel_wdata;
  assign mem_write_enable = w_gnt_any &  w_sel_we & w_in_range;
  assign mem_read_enable  = w_gnt_any & ~w_sel_we & w_in_range;

  // Ownership state and burst counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_burst_cnt <= LP_BURST_ZERO;
    end else begin
      r_state     <= w_next_state;
      r_burst_cnt <= w_next_burst;
    end
  end

  // Read return and error pulse; out-of-range reads return zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rdata      <= '0;
      r_cpu_rvalid <= 1'b0;
      r_ldr_rvalid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_cpu_rvalid <= w_cpu_gnt & ~cpu_we;
      r_ldr_rvalid <= w_ldr_gnt & ~ldr_we;
      r_err        <= w_gnt_any & ~w_in_range;
      if (w_gnt_any && !w_sel_we) begin
        r_rdata <= w_in_range ? mem_read_data : '0;
      end
    end
  end

  assign cpu_gnt    = w_cpu_gnt;
  assign ldr_gnt    = w_ldr_gnt;
  assign cpu_rvalid = r_cpu_rvalid;
  assign ldr_rvalid = r_ldr_rvalid;
  assign rdata      = r_rdata;
  assign err        = r_err;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed self-checking bench for data_memory_arbiter with a small memory model.
module tb_data_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we, ldr_req, ldr_we;
  logic [15:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
  logic        cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, err;
  logic [15:0] rdata;
  logic [15:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable, mem_read_enable;

  logic [15:0] tb_mem [0:511];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  data_memory_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cpu_req          (cpu_req),
    .cpu_we           (cpu_we),
    .cpu_addr         (cpu_addr),
    .cpu_wdata        (cpu_wdata),
    .ldr_req          (ldr_req),
    .ldr_we           (ldr_we),
    .ldr_addr         (ldr_addr),
    .ldr_wdata        (ldr_wdata),
    .cpu_gnt          (cpu_gnt),
    .ldr_gnt          (ldr_gnt),
    .cpu_rvalid       (cpu_rvalid),
    .ldr_rvalid       (ldr_rvalid),
    .rdata            (rdata),
    .err              (err),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_read_data    (mem_read_data)
  );

  // Memory model: preloaded with 0x1000+addr while reset is low.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 512; i++) tb_mem[i] <= 16'h1000 + 16'(i);
    end else if (mem_write_enable) begin
      tb_mem[mem_address[8:0]] <= mem_write_data;
    end
  end
  assign mem_read_data = tb_mem[mem_address[8:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drv_cpu(input logic req, input logic we, input logic [15:0] a, input logic [15:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic drv_ldr(input logic req, input logic we, input logic [15:0] a, input logic [15:0] d);
    ldr_req = req; ldr_we = we; ldr_addr = a; ldr_wdata = d;
  endtask

  // Advance to the next cycle: inputs are applied at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [8:0]  pat_l, pat_c;
    logic [4:0]  pat_l5, pat_c5;
    logic [15:0] exp_rd;
    int li, ci;

    reset_n = 1'b0;
    drv_cpu(1'b0, 1'b0, 16'h0000, 16'h0000);
    drv_ldr(1'b0, 1'b0, 16'h0000, 16'h0000);

    // Reset state, with a request present while reset is low.
    step();
    drv_cpu(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    #1;
    chk("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk("rst_mem_we", mem_write_enable, 1'b0);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_rvalid", {cpu_rvalid, ldr_rvalid}, 2'b00);
    chk("rst_err", err, 1'b0);
    step();
    reset_n = 1'b1;

    // CPU write then read back.
    drv_cpu(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    #1;
    chk("wr_cpu_gnt", cpu_gnt, 1'b1);
    chk("wr_ldr_gnt", ldr_gnt, 1'b0);
    chk("wr_mem_we", mem_write_enable, 1'b1);
    chk("wr_mem_addr", mem_address, 16'h0010);
    chk("wr_mem_wdata", mem_write_data, 16'hBEEF);
    step();
    drv_cpu(1'b1, 1'b0, 16'h0010, 16'h0000);
    #1;
    chk("rd_cpu_gnt", cpu_gnt, 1'b1);
    chk("rd_mem_re", mem_read_enable, 1'b1);
    chk("rd_no_rvalid_after_wr", cpu_rvalid, 1'b0);
    step();
    drv_cpu(1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    chk("rd_cpu_rvalid", cpu_rvalid, 1'b1);
    chk("rd_ldr_rvalid", ldr_rvalid, 1'b0);
    chk("rd_rdata", rdata, 16'hBEEF);
    chk("idle_gnt", {cpu_gnt, ldr_gnt}, 2'b00);
    chk("idle_mem_addr", mem_address, 16'h0000);
    chk("idle_mem_wdata", mem_write_data, 16'h0000);
    step();
    #1;
    chk("rvalid_one_pulse", cpu_rvalid, 1'b0);

    // Simultaneous requests from IDLE: CPU first, loader next.
    drv_cpu(1'b1, 1'b0, 16'h0010, 16'h0000);
    drv_ldr(1'b1, 1'b0, 16'h0011, 16'h0000);
    #1;
    chk("sim_cpu_gnt", cpu_gnt, 1'b1);
    chk("sim_ldr_gnt", ldr_gnt, 1'b0);
    step();
    drv_cpu(1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    chk("sim_ldr_gnt2", ldr_gnt, 1'b1);
    chk("sim_cpu_rvalid", cpu_rvalid, 1'b1);
    chk("sim_rdata_cpu", rdata, 16'hBEEF);
    step();
    drv_ldr(1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    chk("sim_ldr_rvalid", ldr_rvalid, 1'b1);
    chk("sim_cpu_rvalid_off", cpu_rvalid, 1'b0);
    chk("sim_rdata_ldr", rdata, 16'h1011);

    // Burst limit: loader streams, CPU joins and waits.
    pat_l  = 9'b1_0000_1111;
    pat_c  = 9'b0_1111_0000;
    li     = 0;
    ci     = 0;
    exp_rd = 16'h0000;
    for (int k = 0; k < 10; k++) begin
      step();
      drv_ldr((k < 9) ? 1'b1 : 1'b0, 1'b0, 16'h0020 + 16'(li), 16'h0000);
      drv_cpu((k >= 1 && k < 9) ? 1'b1 : 1'b0, 1'b0, 16'h0030 + 16'(ci), 16'h0000);
      #1;
      if (k < 9) begin
        chk($sformatf("burst_cpu_gnt_%0d", k), cpu_gnt, pat_c[k]);
        chk($sformatf("burst_ldr_gnt_%0d", k), ldr_gnt, pat_l[k]);
      end
      if (k > 0) begin
        chk($sformatf("burst_cpu_rvalid_%0d", k), cpu_rvalid, pat_c[k-1]);
        chk($sformatf("burst_ldr_rvalid_%0d", k), ldr_rvalid, pat_l[k-1]);
        chk($sformatf("burst_rdata_%0d", k), rdata, exp_rd);
      end
      if (k < 9) begin
        if (pat_l[k]) begin
          exp_rd = 16'h1020 + 16'(li);
          li++;
        end
        if (pat_c[k]) begin
          exp_rd = 16'h1030 + 16'(ci);
          ci++;
        end
      end
    end

    // Out-of-range loader write, then out-of-range CPU read.
    step();
    drv_ldr(1'b1, 1'b1, 16'h0200, 16'hDEAD);
    #1;
    chk("oor_wr_ldr_gnt", ldr_gnt, 1'b1);
    chk("oor_wr_mem_we", mem_write_enable, 1'b0);
    chk("oor_wr_mem_re", mem_read_enable, 1'b0);
    chk("oor_wr_err_early", err, 1'b0);
    step();
    drv_ldr(1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    chk("oor_wr_err", err, 1'b1);
    chk("oor_wr_no_rvalid", ldr_rvalid, 1'b0);
    chk("oor_wr_mem0", tb_mem[0], 16'h1000);
    step();
    drv_cpu(1'b1, 1'b0, 16'h0300, 16'h0000);
    #1;
    chk("oor_rd_cpu_gnt", cpu_gnt, 1'b1);
    chk("oor_rd_mem_re", mem_read_enable, 1'b0);
    chk("oor_rd_err_clear", err, 1'b0);
    step();
    drv_cpu(1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    chk("oor_rd_rvalid", cpu_rvalid, 1'b1);
    chk("oor_rd_rdata", rdata, 16'h0000);
    chk("oor_rd_err", err, 1'b1);

    // Reset during the CPU's third burst grant.
    step();
    drv_cpu(1'b1, 1'b0, 16'h0040, 16'h0000);
    #1;
    chk("rb_gnt1", cpu_gnt, 1'b1);
    step();
    drv_cpu(1'b1, 1'b0, 16'h0041, 16'h0000);
    #1;
    chk("rb_gnt2", cpu_gnt, 1'b1);
    chk("rb_rdata1", rdata, 16'h1040);
    step();
    drv_cpu(1'b1, 1'b0, 16'h0042, 16'h0000);
    reset_n = 1'b0;
    #1;
    chk("rb_gnt_in_reset", cpu_gnt, 1'b0);
    chk("rb_re_in_reset", mem_read_enable, 1'b0);
    chk("rb_rdata2", rdata, 16'h1041);

    // After reset the CPU must get a fresh full burst of four.
    pat_c5 = 5'b01111;
    pat_l5 = 5'b10000;
    ci     = 0;
    exp_rd = 16'h0000;
    for (int k = 0; k < 6; k++) begin
      step();
      reset_n = 1'b1;
      drv_cpu((k < 5) ? 1'b1 : 1'b0, 1'b0, 16'h0043 + 16'(ci), 16'h0000);
      drv_ldr((k < 5) ? 1'b1 : 1'b0, 1'b0, 16'h0050, 16'h0000);
      #1;
      if (k == 0) begin
        chk("rb_rdata_cleared", rdata, 16'h0000);
        chk("rb_no_rvalid", {cpu_rvalid, ldr_rvalid}, 2'b00);
        chk("rb_err_cleared", err, 1'b0);
      end else begin
        chk($sformatf("rb_cpu_rvalid_%0d", k), cpu_rvalid, pat_c5[k-1]);
        chk($sformatf("rb_ldr_rvalid_%0d", k), ldr_rvalid, pat_l5[k-1]);
        chk($sformatf("rb_rdata_%0d", k), rdata, exp_rd);
      end
      if (k < 5) begin
        chk($sformatf("rb_cpu_gnt_%0d", k), cpu_gnt, pat_c5[k]);
        chk($sformatf("rb_ldr_gnt_%0d", k), ldr_gnt, pat_l5[k]);
        if (pat_c5[k]) begin
          exp_rd = 16'h1043 + 16'(ci);
          ci++;
        end
        if (pat_l5[k]) begin
          exp_rd = 16'h1050;
        end
      end
    end

    // Write-then-read hazard across requesters.
    step();
    drv_cpu(1'b1, 1'b1, 16'h0005, 16'h1234);
    #1;
    chk("hz_cpu_gnt", cpu_gnt, 1'b1);
    chk("hz_mem_we", mem_write_enable, 1'b1);
    step();
    drv_cpu(1'b0, 1'b0, 16'h0000, 16'h0000);
    drv_ldr(1'b1, 1'b0, 16'h0005, 16'h0000);
    #1;
    chk("hz_ldr_gnt", ldr_gnt, 1'b1);
    step();
    drv_ldr(1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    chk("hz_ldr_rvalid", ldr_rvalid, 1'b1);
    chk("hz_cpu_rvalid", cpu_rvalid, 1'b0);
    chk("hz_rdata", rdata, 16'h1234);

    step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
